// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Optional feature macro used by the arbiter files: DMEM_MISALIGN_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int DMEM_BYTES_DEF = 128;

  // Byte-lane mask of an access starting at lane 0; illegal size gives no lanes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size_e'(size))
      SZ_B:    size_mask = 4'b0001;
      SZ_H:    size_mask = 4'b0011;
      SZ_W:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // Number of bytes touched; illegal size reports 0 (always flagged as error).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size_e'(size))
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      SZ_W:    size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data-memory arbiter.
// Stores: byte-lane enables and lane-shifted data (second word only with
// DMEM_MISALIGN_EN). Loads: shift merged read data, mask to size, extend.
module dmem_lane_align
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        wr,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [63:0] rmerge,
  output logic [3:0]  we_lo,
  output logic [31:0] wdata_lo,
`ifdef DMEM_MISALIGN_EN
  output logic [3:0]  we_hi,
  output logic [31:0] wdata_hi,
`endif
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [31:0] rword;

  assign mask = wr ? size_mask(size) : 4'b0000;

`ifdef DMEM_MISALIGN_EN
  // Lanes/data that overflow the first word spill into the next word from lane 0.
  assign {we_hi, we_lo}       = {4'b0000, mask} << off;
  assign {wdata_hi, wdata_lo} = {32'h0, wdata} << {off, 3'b000};
`else
  assign we_lo    = mask << off;
  assign wdata_lo = wdata << {off, 3'b000};
`endif

  assign rword = 32'(rmerge >> {off, 3'b000});

  // Mask load data to its size and extend unless zero-extension requested.
  always_comb begin
    rdata = 32'h0;
    case (size_e'(size))
      SZ_B:    rdata = {{24{~uns & rword[7]}}, rword[7:0]};
      SZ_H:    rdata = {{16{~uns & rword[15]}}, rword[15:0]};
      SZ_W:    rdata = rword;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port byte-addressed data memory.
// Optional feature macro: DMEM_MISALIGN_EN (split misaligned accesses into
// two memory beats; when undefined misaligned accesses return an error).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready offered to round-robin winner; accept latches request
//   S_BEAT1 | first memory word: address, lanes, write data, read capture
//   S_BEAT2 | second word of a split access (misalign build only)
//   S_RESP  | one-cycle response pulse to the owning requester
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DMEM_BYTES = DMEM_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_addr,
  input  logic [NREQ-1:0][31:0] req_wdata,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ-1:0][1:0]  req_size,
  input  logic [NREQ-1:0]       req_unsigned,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           m_daddr,
  output logic [31:0]           m_dwdata,
  output logic [3:0]            m_we,
  input  logic [31:0]           m_drdata
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  state_e        state, state_nxt;
  logic [PW-1:0] ptr, own, grant_idx;
  logic [PW:0]   cand;
  logic          grant_found, accept;

  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    size_q;
  logic          wr_q, uns_q, err_q;
  logic [31:0]   merge_lo;
  logic [31:0]   daddr_hold, dwdata_hold;
  logic [63:0]   rmerge;

  logic [31:0]   sel_addr;
  logic [1:0]    sel_size;
  logic [2:0]    sel_nbytes;
  logic [32:0]   sel_end;
  logic          sel_err;

  logic [3:0]    we_lo;
  logic [31:0]   wdata_lo, lane_rdata;

`ifdef DMEM_MISALIGN_EN
  logic          split_q, sel_split;
  logic [31:0]   merge_hi;
  logic [3:0]    we_hi;
  logic [31:0]   wdata_hi;
  assign rmerge = {merge_hi, merge_lo};
`else
  logic          sel_mis;
  assign rmerge = {32'h0, merge_lo};
`endif

  // Round-robin pick: first valid requester at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!grant_found && req_valid[cand[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

  // Accept-time error and split classification of the winning request.
  always_comb begin
    sel_addr   = req_addr[grant_idx];
    sel_size   = req_size[grant_idx];
    sel_nbytes = size_bytes(sel_size);
    sel_end    = {1'b0, sel_addr} + {30'd0, sel_nbytes} - 33'd1;
`ifdef DMEM_MISALIGN_EN
    sel_split  = ({1'b0, sel_addr[1:0]} + sel_nbytes) > 3'd4;
    sel_err    = (sel_size == 2'd3) || (sel_end >= 33'(DMEM_BYTES));
`else
    sel_mis    = (sel_addr[1:0] & 2'(sel_nbytes - 3'd1)) != 2'b00;
    sel_err    = (sel_size == 2'd3) || (sel_end >= 33'(DMEM_BYTES)) || sel_mis;
`endif
  end

  dmem_lane_align u_lane (
    .off      (addr_q[1:0]),
    .size     (size_q),
    .wr       (wr_q),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .rmerge   (rmerge),
    .we_lo    (we_lo),
    .wdata_lo (wdata_lo),
`ifdef DMEM_MISALIGN_EN
    .we_hi    (we_hi),
    .wdata_hi (wdata_hi),
`endif
    .rdata    (lane_rdata)
  );

  // FSM next state and all handshake/memory outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    m_we      = 4'b0000;
    m_daddr   = daddr_hold;
    m_dwdata  = dwdata_hold;
    case (state)
      S_IDLE: begin
        if (grant_found && !rst) begin
          req_ready = NREQ'(1) << grant_idx;
          accept    = 1'b1;
          state_nxt = sel_err ? S_RESP : S_BEAT1;
        end
      end
      S_BEAT1: begin
        m_daddr  = {addr_q[31:2], 2'b00};
        m_we     = we_lo;
        m_dwdata = wdata_lo;
`ifdef DMEM_MISALIGN_EN
        state_nxt = split_q ? S_BEAT2 : S_RESP;
`else
        state_nxt = S_RESP;
`endif
      end
`ifdef DMEM_MISALIGN_EN
      S_BEAT2: begin
        m_daddr   = {addr_q[31:2], 2'b00} + 32'd4;
        m_we      = we_hi;
        m_dwdata  = wdata_hi;
        state_nxt = S_RESP;
      end
`endif
      S_RESP: begin
        rsp_valid = NREQ'(1) << own;
        rsp_err   = err_q;
        rsp_rdata = (err_q || wr_q) ? 32'h0 : lane_rdata;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Pointer advance and request latch on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      own     <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_EN
      split_q <= 1'b0;
`endif
    end else if (accept) begin
      ptr     <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      own     <= grant_idx;
      addr_q  <= sel_addr;
      wdata_q <= req_wdata[grant_idx];
      size_q  <= sel_size;
      wr_q    <= req_wr[grant_idx];
      uns_q   <= req_unsigned[grant_idx];
      err_q   <= sel_err;
`ifdef DMEM_MISALIGN_EN
      split_q <= sel_split;
`endif
    end
  end

  // Read-data merge capture and hold of the last memory address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      merge_lo    <= 32'h0;
`ifdef DMEM_MISALIGN_EN
      merge_hi    <= 32'h0;
`endif
      daddr_hold  <= 32'h0;
      dwdata_hold <= 32'h0;
    end else begin
      if (state == S_BEAT1) merge_lo <= m_drdata;
`ifdef DMEM_MISALIGN_EN
      if (state == S_BEAT2) merge_hi <= m_drdata;
`endif
      if (state == S_BEAT1 || state == S_BEAT2) begin
        daddr_hold  <= m_daddr;
        dwdata_hold <= m_dwdata;
      end
    end
  end

endmodule
